video_pattern_generator: RTL

//  Parametrised Avalon-ST video source: emits Width*Height pixel frames with

---
 rtl/video_pattern_generator.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/video_pattern_generator.sv
// Avalon-ST test-pattern source: streams Width x Height frames (solid, colour bars,
// checkerboard, gradient) with sop/eop framing, sink backpressure and an inter-frame gap.
module video_pattern_generator #(
    parameter int Width       = 12,
    parameter int Height      = 12,
    parameter int NumChannels = 3,
    parameter int ChannelBits = 1,
    parameter int CheckShift  = 1,
    parameter int BarShift    = 2,
    parameter int FrameGap    = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic [1:0]                           mode,
    input  logic [NumChannels*ChannelBits-1:0]   solid_colour,
    output logic [NumChannels*ChannelBits-1:0]   data,
    output logic                                 startofpacket,
    output logic                                 endofpacket,
    output logic                                 valid,
    input  logic                                 ready,
    output logic [15:0]                          frame_count,
    output logic                                 busy
);

    localparam int DW = NumChannels * ChannelBits;
    localparam int XW = $clog2(Width);
    localparam int YW = (Height > 1) ? $clog2(Height) : 1;
    localparam int GW = (FrameGap > 1) ? $clog2(FrameGap) : 1;

    localparam logic [XW-1:0] X_LAST       = XW'(Width - 1);
    localparam logic [YW-1:0] Y_LAST       = YW'(Height - 1);
    localparam logic [GW-1:0] GAP_LAST     = GW'((FrameGap > 0) ? FrameGap - 1 : 0);
    localparam logic          SINGLE_PIXEL = (Width * Height == 1);
    localparam logic [ChannelBits-1:0] ONES = {ChannelBits{1'b1}};
    localparam logic [ChannelBits-1:0] ZERO = {ChannelBits{1'b0}};

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        GAP
    } state_t;

    state_t          state_reg, state_next;
    logic [XW-1:0]   x_reg, x_next, x_adv;
    logic [YW-1:0]   y_reg, y_next, y_adv;
    logic [GW-1:0]   gap_reg, gap_next;
    logic [1:0]      mode_reg, mode_next;
    logic [DW-1:0]   solid_reg, solid_next;
    logic [15:0]     fc_reg, fc_next;
    logic [DW-1:0]   data_reg, data_next;
    logic            sop_reg, sop_next;
    logic            eop_reg, eop_next;
    logic            valid_reg, valid_next;
    logic            start_frame;

    // Colour bars start white: a set bar-index bit blanks its channel.
    function automatic logic [DW-1:0] pixel_value(
        input logic [1:0]    pm,
        input logic [DW-1:0] sc,
        input logic [XW-1:0] px,
        input logic [YW-1:0] py
    );
        logic [DW-1:0]             v;
        logic [XW+2:0]             bars;
        logic [XW:0]               cx;
        logic [YW:0]               cy;
        logic [XW+ChannelBits-1:0] gx;
        v    = '0;
        bars = {3'b000, px} >> BarShift;
        cx   = {1'b0, px} >> CheckShift;
        cy   = {1'b0, py} >> CheckShift;
        gx   = {{ChannelBits{1'b0}}, px};
        case (pm)
            2'd0: v = sc;
            2'd1: begin
                for (int c = 0; c < NumChannels; c++) begin
                    v[c*ChannelBits +: ChannelBits] = bars[c % 3] ? ZERO : ONES;
                end
            end
            2'd2: v = (cx[0] ^ cy[0]) ? '0 : sc;
            default: begin
                for (int c = 0; c < NumChannels; c++) begin
                    v[c*ChannelBits +: ChannelBits] = gx[ChannelBits-1:0];
                end
            end
        endcase
        return v;
    endfunction

    // Raster position following the pixel currently presented.
    always_comb begin
        x_adv = x_reg + 1'b1;
        y_adv = y_reg;
        if (x_reg == X_LAST) begin
            x_adv = '0;
            y_adv = (y_reg == Y_LAST) ? '0 : y_reg + 1'b1;
        end
    end

    always_comb begin
        state_next  = state_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        gap_next    = gap_reg;
        mode_next   = mode_reg;
        solid_next  = solid_reg;
        fc_next     = fc_reg;
        data_next   = data_reg;
        sop_next    = sop_reg;
        eop_next    = eop_reg;
        valid_next  = valid_reg;
        start_frame = 1'b0;

        case (state_reg)
            IDLE: begin
                if (enable) begin
                    start_frame = 1'b1;
                end
            end
            STREAM: begin
                if (valid_reg && ready) begin
                    if (eop_reg) begin
                        fc_next    = fc_reg + 16'd1;
                        valid_next = 1'b0;
                        sop_next   = 1'b0;
                        eop_next   = 1'b0;
                        x_next     = '0;
                        y_next     = '0;
                        if (FrameGap == 0) begin
                            if (enable) begin
                                start_frame = 1'b1;
                            end else begin
                                state_next = IDLE;
                            end
                        end else begin
                            state_next = GAP;
                            gap_next   = '0;
                        end
                    end else begin
                        x_next    = x_adv;
                        y_next    = y_adv;
                        data_next = pixel_value(mode_reg, solid_reg, x_adv, y_adv);
                        sop_next  = 1'b0;
                        eop_next  = (x_adv == X_LAST) && (y_adv == Y_LAST);
                    end
                end
            end
            GAP: begin
                if (gap_reg == GAP_LAST) begin
                    if (enable) begin
                        start_frame = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase

        // Frame start latches mode/colour and presents pixel (0,0) immediately.
        if (start_frame) begin
            state_next = STREAM;
            x_next     = '0;
            y_next     = '0;
            mode_next  = mode;
            solid_next = solid_colour;
            valid_next = 1'b1;
            data_next  = pixel_value(mode, solid_colour, '0, '0);
            sop_next   = 1'b1;
            eop_next   = SINGLE_PIXEL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            gap_reg   <= '0;
            mode_reg  <= '0;
            solid_reg <= '0;
            fc_reg    <= '0;
            data_reg  <= '0;
            sop_reg   <= 1'b0;
            eop_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            gap_reg   <= gap_next;
            mode_reg  <= mode_next;
            solid_reg <= solid_next;
            fc_reg    <= fc_next;
            data_reg  <= data_next;
            sop_reg   <= sop_next;
            eop_reg   <= eop_next;
            valid_reg <= valid_next;
        end
    end

    assign data          = data_reg;
    assign startofpacket = sop_reg;
    assign endofpacket   = eop_reg;
    assign valid         = valid_reg;
    assign frame_count   = fc_reg;
    assign busy          = (state_reg != IDLE);

endmodule
